adc_snapshot_sequencer: RTL and testbench
=========================================

// Module: adc_snapshot_sequencer
//
// PURPOSE
//  Sequences single-shot snapshot captures of the RFDC ADC AXI4-Stream (128-bit, 8 x 16-bit samples/beat)
//  into a PL block RAM. The PS arms it; it then waits for the selected trigger (immediate, PL-captured
//  SYSREF edge, or external/ILA trigger pulse), applies a programmable holdoff, writes LENGTH+1 beats and
//  flags done until acknowledged. Sits between the RFDC m00_axis output and the snapshot BRAM write port.
//
// PARAMETERS
//  DATA_WIDTH   128  stream/BRAM word width (bits)
//  ADDR_WIDTH   10   BRAM address width; max capture = 2**ADDR_WIDTH beats
//  DELAY_WIDTH  16   holdoff counter width (aclk cycles)
//
// PORTS
//  aclk          in   1            ADC AXI4-Stream clock; all ports synchronous to it
//  aresetn       in   1            asynchronous active-low reset
//  arm_i         in   1            1-cycle pulse: start a capture (accepted in IDLE only)
//  abort_i       in   1            level/pulse: cancel any capture in progress
//  trig_src_i    in   2            0=immediate, 1=SYSREF rising edge, 2=trig_i, 3=reserved (acts as 0)
//  sysref_i      in   1            SYSREF level, already registered in aclk domain
//  trig_i        in   1            external trigger pulse (e.g. ILA trig_out)
//  trig_ack_o    out  1            1-cycle pulse when a trigger event is consumed
//  delay_i       in   DELAY_WIDTH  holdoff cycles between trigger and first write
//  length_i      in   ADDR_WIDTH   capture length minus one, in beats
//  s_axis_tdata  in   DATA_WIDTH   ADC stream data (no tready: source cannot stall)
//  s_axis_tvalid in   1            ADC stream valid
//  buf_we_o      out  1            BRAM write enable
//  buf_addr_o    out  ADDR_WIDTH   BRAM write address
//  buf_data_o    out  DATA_WIDTH   BRAM write data
//  busy_o        out  1            high in any state except IDLE and DONE
//  done_o        out  1            high in DONE
//  done_ack_i    in   1            pulse: release DONE
//
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; counters 0. All outputs registered.
//  - trig_src_i, delay_i and length_i are latched on the accepted arm_i; later changes are ignored.
//  - SYSREF edge = sysref_i==1 and its 1-cycle delayed copy==0; the delay register runs in all states.
//  - FSM: IDLE -(arm_i)-> WAIT_TRIG; WAIT_TRIG -(event)-> HOLDOFF, or CAPTURE if delay==0;
//    HOLDOFF counts delay cycles -> CAPTURE; CAPTURE -(last beat written)-> DONE;
//    DONE -(done_ack_i)-> IDLE.
//  - Immediate source: the event is the cycle after arm_i is accepted (WAIT_TRIG lasts 1 cycle).
//  - trig_ack_o pulses for exactly 1 cycle, on the cycle after the event is detected, for every source.
//    Events outside WAIT_TRIG are ignored and are not acked.
//  - HOLDOFF: with delay=D>0, the first beat eligible for writing is the one presented D+1 cycles after
//    the event cycle (delay=0 gives 1 cycle).
//  - CAPTURE: each beat with tvalid=1 is written. Beats with tvalid=0 are skipped (no write, address held).
//    Address starts at 0 and increments per write. After length+1 writes -> DONE; no wrap-around occurs.
//  - Write latency: a beat sampled at edge N appears on buf_we/addr/data after edge N. Outside a write,
//    buf_we_o=0 and buf_data_o holds its last value.
//  - abort_i in any state except IDLE -> IDLE at the next edge. The abort beat and later beats are not
//    written. done_o and busy_o clear, and no trig_ack_o is issued afterwards.
//  - Simultaneous events:
//    - arm_i with abort_i: abort wins (stays IDLE).
//    - done_ack_i with arm_i in DONE: go to IDLE; the arm is ignored.
//    - arm_i while busy or done: ignored.
//    - Trigger event on the same cycle as abort_i: no ack.
//  - Async reset mid-capture: immediate IDLE. Partial BRAM contents are undefined to the consumer.
//
// TESTING
//  1. src=0, delay=0, len=3, tvalid=1 words 0xA..0xD from the arm cycle: 4 writes at addr 0..3, then
//     done_o=1, busy_o=0, one trig_ack_o.
//  2. src=1, delay=5, len=7: SYSREF rises at cycle T -> trig_ack at T+1; first write holds the beat
//     sampled at T+6; 8 writes, addr 0..7.
//  3. tvalid pattern 1,0,0,1,1 during CAPTURE, len=2 -> exactly 3 writes at consecutive addresses 0,1,2
//     with the valid beats' data.
//  4. abort_i asserted after 2 of 8 writes -> IDLE next cycle, no further buf_we_o, done_o never set.
//     A new arm captures from addr 0.
//  5. trig_i pulses in IDLE and DONE -> no trig_ack_o. arm_i in DONE ignored. done_ack_i -> IDLE.
//  6. arm_i+abort_i same cycle -> remains IDLE. Async reset mid-HOLDOFF -> all outputs 0 immediately.

Source files
------------

// File: rtl/adc_snapshot_sequencer_if.sv
// Signal bundle between the snapshot sequencer, its PS/trigger control, the RFDC ADC
// stream and the snapshot BRAM write port. The sequencer uses the slave view.
interface adc_snapshot_sequencer_if #(
  parameter int DATA_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 10,
  parameter int DELAY_WIDTH = 16
);
  logic                   arm_i;
  logic                   abort_i;
  logic [1:0]             trig_src_i;
  logic                   sysref_i;
  logic                   trig_i;
  logic                   trig_ack_o;
  logic [DELAY_WIDTH-1:0] delay_i;
  logic [ADDR_WIDTH-1:0]  length_i;
  logic [DATA_WIDTH-1:0]  s_axis_tdata;
  logic                   s_axis_tvalid;
  logic                   buf_we_o;
  logic [ADDR_WIDTH-1:0]  buf_addr_o;
  logic [DATA_WIDTH-1:0]  buf_data_o;
  logic                   busy_o;
  logic                   done_o;
  logic                   done_ack_i;

  modport slave (
    input  arm_i, abort_i, trig_src_i, sysref_i, trig_i, delay_i, length_i,
           s_axis_tdata, s_axis_tvalid, done_ack_i,
    output trig_ack_o, buf_we_o, buf_addr_o, buf_data_o, busy_o, done_o
  );

  modport master (
    output arm_i, abort_i, trig_src_i, sysref_i, trig_i, delay_i, length_i,
           s_axis_tdata, s_axis_tvalid, done_ack_i,
    input  trig_ack_o, buf_we_o, buf_addr_o, buf_data_o, busy_o, done_o
  );
endinterface

// File: rtl/adc_snapshot_sequencer.sv
// Single-shot snapshot sequencer: arm, wait for trigger, hold off, then write LENGTH+1
// valid ADC beats into the snapshot BRAM and hold done until acknowledged.
module adc_snapshot_sequencer #(
  parameter int DATA_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 10,
  parameter int DELAY_WIDTH = 16
) (
  input logic                     aclk,
  input logic                     aresetn,
  adc_snapshot_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WAIT_TRIG, HOLDOFF, CAPTURE, DONE} state_t;

  state_t                 state;
  logic                   sysref_q;
  logic [1:0]             src_q;
  logic [DELAY_WIDTH-1:0] delay_q;
  logic [DELAY_WIDTH-1:0] hold_cnt;
  logic [ADDR_WIDTH-1:0]  len_q;
  logic [ADDR_WIDTH-1:0]  wr_cnt;
  logic                   trig_event;

  logic                   trig_ack;
  logic                   buf_we;
  logic [ADDR_WIDTH-1:0]  buf_addr;
  logic [DATA_WIDTH-1:0]  buf_data;
  logic                   busy;
  logic                   done;

  // Reserved source 3 behaves like immediate.
  // NOTE: the default arm assigns trig_event on every path, so no latch is inferred.
  always_comb begin
    case (src_q)
      2'd1:    trig_event = bus.sysref_i & ~sysref_q;
      2'd2:    trig_event = bus.trig_i;
      default: trig_event = 1'b1;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      // NOTE: the wide data register is reset too, because every output must read 0 out of reset.
      state    <= IDLE;
      sysref_q <= 1'b0;
      src_q    <= '0;
      delay_q  <= '0;
      hold_cnt <= '0;
      len_q    <= '0;
      wr_cnt   <= '0;
      trig_ack <= 1'b0;
      buf_we   <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      sysref_q <= bus.sysref_i;
      trig_ack <= 1'b0;
      buf_we   <= 1'b0;

      if (bus.abort_i && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.arm_i && !bus.abort_i) begin
              src_q   <= bus.trig_src_i;
              delay_q <= bus.delay_i;
              len_q   <= bus.length_i;
              wr_cnt  <= '0;
              busy    <= 1'b1;
              state   <= WAIT_TRIG;
            end
          end
          WAIT_TRIG: begin
            if (trig_event) begin
              trig_ack <= 1'b1;
              if (delay_q == '0) begin
                state <= CAPTURE;
              end else begin
                hold_cnt <= delay_q - DELAY_WIDTH'(1);
                state    <= HOLDOFF;
              end
            end
          end
          HOLDOFF: begin
            if (hold_cnt == '0) state <= CAPTURE;
            else                hold_cnt <= hold_cnt - DELAY_WIDTH'(1);
          end
          CAPTURE: begin
            if (bus.s_axis_tvalid) begin
              buf_we   <= 1'b1;
              buf_addr <= wr_cnt;
              buf_data <= bus.s_axis_tdata;
              wr_cnt   <= wr_cnt + ADDR_WIDTH'(1);
              if (wr_cnt == len_q) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end
            end
          end
          DONE: begin
            if (bus.done_ack_i) begin
              done  <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.trig_ack_o = trig_ack;
  assign bus.buf_we_o   = buf_we;
  assign bus.buf_addr_o = buf_addr;
  assign bus.buf_data_o = buf_data;
  assign bus.busy_o     = busy;
  assign bus.done_o     = done;

endmodule

// File: tb/tb_adc_snapshot_sequencer.sv
// Bench for adc_snapshot_sequencer: directed table, directed traces with hand-derived
// checks, and random traces compared against a trace-level reference model.
module tb_adc_snapshot_sequencer;
  localparam int DW = 128;
  localparam int AW = 10;
  localparam int LW = 16;
  localparam int NC = 160;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  adc_snapshot_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DELAY_WIDTH(LW)) bus ();

  adc_snapshot_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DELAY_WIDTH(LW)) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Per-cycle stimulus, observed outputs and model expectations for one trace.
  logic          arm_v [NC], abort_v [NC], sys_v [NC], trig_v [NC], val_v [NC], dack_v [NC];
  logic [1:0]    src_v [NC];
  logic [LW-1:0] dly_v [NC];
  logic [AW-1:0] len_v [NC];
  logic [DW-1:0] dat_v [NC];
  logic          o_we [NC], o_ack [NC], o_busy [NC], o_done [NC];
  logic [AW-1:0] o_addr [NC];
  logic [DW-1:0] o_data [NC];
  logic          e_we [NC], e_ack [NC], e_busy [NC], e_done [NC];
  logic [AW-1:0] e_addr [NC];
  logic [DW-1:0] e_data [NC];

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_idle();
    bus.arm_i = 1'b0; bus.abort_i = 1'b0; bus.trig_src_i = '0; bus.sysref_i = 1'b0;
    bus.trig_i = 1'b0; bus.delay_i = '0; bus.length_i = '0; bus.s_axis_tdata = '0;
    bus.s_axis_tvalid = 1'b0; bus.done_ack_i = 1'b0;
  endtask

  task automatic apply_reset();
    drive_idle();
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #2 aresetn = 1'b1;
  endtask

  task automatic clear_stim(input logic [1:0] src, input int dly, input int len);
    for (int c = 0; c < NC; c++) begin
      arm_v[c] = 0; abort_v[c] = 0; sys_v[c] = 0; trig_v[c] = 0; val_v[c] = 0; dack_v[c] = 0;
      src_v[c] = src; dly_v[c] = LW'(dly); len_v[c] = AW'(len); dat_v[c] = rand_word();
    end
  endtask

  task automatic run_trace();
    apply_reset();
    for (int c = 0; c < NC; c++) begin
      bus.arm_i = arm_v[c]; bus.abort_i = abort_v[c]; bus.sysref_i = sys_v[c];
      bus.trig_i = trig_v[c]; bus.s_axis_tvalid = val_v[c]; bus.done_ack_i = dack_v[c];
      bus.trig_src_i = src_v[c]; bus.delay_i = dly_v[c]; bus.length_i = len_v[c];
      bus.s_axis_tdata = dat_v[c];
      @(posedge aclk);
      #1;
      o_we[c] = bus.buf_we_o; o_ack[c] = bus.trig_ack_o; o_busy[c] = bus.busy_o;
      o_done[c] = bus.done_o; o_addr[c] = bus.buf_addr_o; o_data[c] = bus.buf_data_o;
    end
    drive_idle();
  endtask

  // Reference model over a whole trace: find each accepted arm, its trigger cycle, the
  // first eligible beat after the holdoff, the valid beats written, and the release cycle.
  // Index c of e_* describes the outputs visible just after the edge closing cycle c.
  function automatic void model();
    int c, a, e, t, r, nwr, nlen;
    logic hit;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    for (int i = 0; i < NC; i++) begin
      e_we[i] = 0; e_ack[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_addr[i] = '0; e_data[i] = '0;
    end
    c = 0;
    while (c < NC) begin
      if (!arm_v[c] || abort_v[c]) begin
        c++;
        continue;
      end
      a = c;
      nlen = int'(len_v[a]) + 1;
      e = a + 1;
      hit = 0;
      while (e < NC && !abort_v[e]) begin
        case (src_v[a])
          2'd1:    hit = sys_v[e] && !sys_v[e-1];
          2'd2:    hit = trig_v[e];
          default: hit = 1;
        endcase
        if (hit) break;
        e++;
      end
      if (!hit) begin
        for (int i = a; i < e && i < NC; i++) e_busy[i] = 1;
        c = e + 1;
        continue;
      end
      e_ack[e] = 1;
      t = e + 1;
      for (int k = 0; k < int'(dly_v[a]) && t < NC && !abort_v[t]; k++) t++;
      nwr = 0;
      while (t < NC && !abort_v[t]) begin
        if (val_v[t]) begin
          e_we[t] = 1; e_addr[t] = AW'(nwr); e_data[t] = dat_v[t];
          nwr++;
          if (nwr == nlen) break;
        end
        t++;
      end
      for (int i = a; i < t && i < NC; i++) e_busy[i] = 1;
      if (t >= NC || nwr < nlen) begin
        c = t + 1;
        continue;
      end
      r = t + 1;
      while (r < NC && !dack_v[r] && !abort_v[r]) r++;
      for (int i = t; i < r && i < NC; i++) e_done[i] = 1;
      c = r + 1;
    end
    addr = '0;
    data = '0;
    for (int i = 0; i < NC; i++) begin
      if (e_we[i]) begin
        addr = e_addr[i];
        data = e_data[i];
      end
      e_addr[i] = addr;
      e_data[i] = data;
    end
  endfunction

  task automatic compare_trace(input string tag);
    model();
    for (int c = 0; c < NC; c++) begin
      check($sformatf("%s c%0d we", tag, c), o_we[c], e_we[c]);
      check($sformatf("%s c%0d ack", tag, c), o_ack[c], e_ack[c]);
      check($sformatf("%s c%0d busy", tag, c), o_busy[c], e_busy[c]);
      check($sformatf("%s c%0d done", tag, c), o_done[c], e_done[c]);
      check($sformatf("%s c%0d addr", tag, c), o_addr[c], e_addr[c]);
      check($sformatf("%s c%0d data", tag, c), o_data[c], e_data[c]);
    end
  endtask

  function automatic int count_of(input int kind, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) begin
      case (kind)
        0:       if (o_we[i])   n++;
        1:       if (o_ack[i])  n++;
        default: if (o_done[i]) n++;
      endcase
    end
    return n;
  endfunction

  function automatic int first_we(input int lo);
    for (int i = lo; i < NC; i++) if (o_we[i]) return i;
    return -1;
  endfunction

  // Directed vector table: inputs {arm,abort,trig,done_ack,tvalid} + data byte,
  // expected we, addr, data byte and {ack,busy,done}; config src=0 delay=0 len=3.
  typedef struct {
    logic [4:0]    in_bits;
    logic [7:0]    dat;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic [2:0]    flags;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{5'b10001, 8'h01, 1'b0, 10'd0, 8'h00, 3'b010};  // arm
    vecs[1] = '{5'b00001, 8'h02, 1'b0, 10'd0, 8'h00, 3'b110};  // immediate event, ack next
    vecs[2] = '{5'b00001, 8'h0A, 1'b1, 10'd0, 8'h0A, 3'b010};
    vecs[3] = '{5'b00001, 8'h0B, 1'b1, 10'd1, 8'h0B, 3'b010};
    vecs[4] = '{5'b00001, 8'h0C, 1'b1, 10'd2, 8'h0C, 3'b010};
    vecs[5] = '{5'b00001, 8'h0D, 1'b1, 10'd3, 8'h0D, 3'b001};  // last beat -> done
    vecs[6] = '{5'b10101, 8'h0E, 1'b0, 10'd3, 8'h0D, 3'b001};  // arm+trig in DONE ignored
    vecs[7] = '{5'b00010, 8'h0F, 1'b0, 10'd3, 8'h0D, 3'b000};  // done_ack releases
    vecs[8] = '{5'b00100, 8'h10, 1'b0, 10'd3, 8'h0D, 3'b000};  // trig in IDLE ignored
    vecs[9] = '{5'b00000, 8'h11, 1'b0, 10'd3, 8'h0D, 3'b000};

    // Reset state
    apply_reset();
    #1;
    check("reset we", bus.buf_we_o, 0);
    check("reset busy", bus.busy_o, 0);
    check("reset done", bus.done_o, 0);
    check("reset ack", bus.trig_ack_o, 0);
    check("reset data", bus.buf_data_o, 0);

    // Table: immediate capture, arm/trig ignored in DONE and IDLE, done_ack
    bus.trig_src_i = 2'd0; bus.delay_i = '0; bus.length_i = AW'(3);
    for (int i = 0; i < 10; i++) begin
      {bus.arm_i, bus.abort_i, bus.trig_i, bus.done_ack_i, bus.s_axis_tvalid} = vecs[i].in_bits;
      bus.s_axis_tdata = DW'(vecs[i].dat);
      @(posedge aclk);
      #1;
      check($sformatf("vec%0d we", i), bus.buf_we_o, vecs[i].we);
      check($sformatf("vec%0d addr", i), bus.buf_addr_o, vecs[i].addr);
      check($sformatf("vec%0d data", i), bus.buf_data_o, DW'(vecs[i].data));
      check($sformatf("vec%0d ack", i), bus.trig_ack_o, vecs[i].flags[2]);
      check($sformatf("vec%0d busy", i), bus.busy_o, vecs[i].flags[1]);
      check($sformatf("vec%0d done", i), bus.done_o, vecs[i].flags[0]);
    end

    // arm with abort stays idle; async reset mid-holdoff clears outputs at once
    drive_idle();
    bus.arm_i = 1'b1; bus.abort_i = 1'b1;
    @(posedge aclk);
    #1;
    check("arm+abort busy", bus.busy_o, 0);
    bus.abort_i = 1'b0; bus.delay_i = LW'(20); bus.length_i = AW'(3);
    @(posedge aclk);
    #1;
    bus.arm_i = 1'b0; bus.delay_i = '0;
    repeat (3) @(posedge aclk);
    #1;
    check("holdoff busy", bus.busy_o, 1);
    #2 aresetn = 1'b0;
    #1;
    check("async rst busy", bus.busy_o, 0);
    check("async rst done", bus.done_o, 0);
    check("async rst we", bus.buf_we_o, 0);
    check("async rst addr", bus.buf_addr_o, 0);
    check("async rst data", bus.buf_data_o, 0);
    check("async rst ack", bus.trig_ack_o, 0);

    // SYSREF source, delay 5, len 7: rise at T=6 (an earlier rise before arm is ignored)
    clear_stim(2'd1, 5, 7);
    arm_v[2] = 1;
    for (int c = 0; c < NC; c++) val_v[c] = 1;
    sys_v[0] = 1; sys_v[1] = 1;
    for (int c = 6; c < 10; c++) sys_v[c] = 1;
    run_trace();
    check("sysref ack at T", o_ack[6], 1);
    check("sysref ack count", count_of(1, 0, NC-1), 1);
    check("sysref first write", first_we(0), 12);
    check("sysref first data", o_data[12], dat_v[12]);
    check("sysref writes", count_of(0, 0, NC-1), 8);
    check("sysref last addr", o_addr[19], 7);
    check("sysref done", o_done[19], 1);
    check("sysref busy off", o_busy[19], 0);
    compare_trace("sysref");

    // tvalid gaps during capture, len 2
    clear_stim(2'd0, 0, 2);
    arm_v[0] = 1;
    val_v[2] = 1; val_v[5] = 1; val_v[6] = 1;
    for (int c = 7; c < 20; c++) val_v[c] = 1;
    run_trace();
    check("gaps writes", count_of(0, 0, NC-1), 3);
    check("gaps addr1", o_addr[5], 1);
    check("gaps data1", o_data[5], dat_v[5]);
    check("gaps addr2", o_addr[6], 2);
    check("gaps done", o_done[6], 1);
    compare_trace("gaps");

    // abort after 2 writes, trig in IDLE ignored, re-arm restarts at address 0
    clear_stim(2'd2, 0, 7);
    arm_v[0] = 1; trig_v[3] = 1; abort_v[6] = 1; trig_v[8] = 1;
    arm_v[10] = 1; trig_v[14] = 1;
    for (int c = 0; c < NC; c++) val_v[c] = 1;
    run_trace();
    check("abort writes", count_of(0, 0, 9), 2);
    check("abort we", o_we[6], 0);
    check("abort busy", o_busy[6], 0);
    check("abort no done", count_of(2, 0, 9), 0);
    check("abort ack count", count_of(1, 0, 9), 1);
    check("rearm first write", first_we(10), 15);
    check("rearm addr", o_addr[15], 0);
    compare_trace("abort");

    // Random traces against the reference model
    for (int s = 0; s < 25; s++) begin
      for (int c = 0; c < NC; c++) begin
        arm_v[c]   = ($urandom_range(0, 5) == 0);
        abort_v[c] = ($urandom_range(0, 59) == 0);
        trig_v[c]  = ($urandom_range(0, 7) == 0);
        val_v[c]   = ($urandom_range(0, 3) != 0);
        dack_v[c]  = ($urandom_range(0, 5) == 0);
        sys_v[c]   = (c > 0 ? sys_v[c-1] : 1'b0) ^ ($urandom_range(0, 3) == 0);
        src_v[c]   = 2'($urandom_range(0, 3));
        dly_v[c]   = LW'($urandom_range(0, 6));
        len_v[c]   = AW'($urandom_range(0, 9));
        dat_v[c]   = rand_word();
      end
      run_trace();
      compare_trace($sformatf("rnd%0d", s));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
